// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and constants for the add_cmd command front-end
package add_pkg;

    typedef enum logic [1:0] {
        OP_PING  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_RUN   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ID_CC = 2'd0,
        ID_RA = 2'd1,
        ID_RB = 2'd2,
        ID_RY = 2'd3
    } reg_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] PING_WORD = 32'hdeadbeef;

endpackage

// File: rtl/add_cmd_regs.sv
// rtl/add_cmd_regs.sv - ra/rb/ry lane banks with host write/read ports and run-lane add port
module add_cmd_regs
    import add_pkg::*;
#(
    parameter int LANES = 1,
    parameter int LW    = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  reg_id_t       wr_id,
    input  logic [31:0]   wr_addr,
    input  logic [31:0]   wr_data,
    input  reg_id_t       rd_id,
    input  logic [31:0]   rd_addr,
    output logic [31:0]   rd_data,
    input  logic          run_en,
    input  logic [LW-1:0] run_lane
);

    logic [31:0] ra [LANES];
    logic [31:0] rb [LANES];
    logic [31:0] ry [LANES];

    // Lane decode by comparison keeps out-of-range addresses from aliasing onto a lane.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                ra[i] <= '0;
                rb[i] <= '0;
                ry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_en && wr_addr == 32'(i)) begin
                    case (wr_id)
                        ID_RA:   ra[i] <= wr_data;
                        ID_RB:   rb[i] <= wr_data;
                        ID_RY:   ry[i] <= wr_data;
                        default: ;
                    endcase
                end
                if (run_en && run_lane == LW'(i)) begin
                    ry[i] <= ra[i] + rb[i];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (rd_addr == 32'(i)) begin
                case (rd_id)
                    ID_RA:   rd_data = ra[i];
                    ID_RB:   rd_data = rb[i];
                    ID_RY:   rd_data = ry[i];
                    default: rd_data = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/add_cmd.sv
// rtl/add_cmd.sv - command/response front-end sequencing lane-serial ry = ra + rb
module add_cmd
    import add_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_id,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t      state;
    state_t      state_nx;
    logic [LW-1:0] lane;
    logic [31:0] cc;
    logic [31:0] rsp_q;
    logic [31:0] bank_rd;
    op_t         op;
    reg_id_t     id;
    logic        accept;
    logic        last_lane;

    assign op        = op_t'(cmd_op);
    assign id        = reg_id_t'(cmd_id);
    assign accept    = cmd_valid && cmd_ready;
    assign last_lane = (lane == LW'(LANES - 1));
    assign rsp_data  = rsp_q;

    add_cmd_regs #(
        .LANES(LANES),
        .LW   (LW)
    ) u_regs (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept && op == OP_WRITE && id != ID_CC),
        .wr_id   (id),
        .wr_addr (cmd_addr),
        .wr_data (cmd_data),
        .rd_id   (id),
        .rd_addr (cmd_addr),
        .rd_data (bank_rd),
        .run_en  (state == ST_RUN),
        .run_lane(lane)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = (op == OP_RUN) ? ST_RUN : ST_RESP;
                end
            end
            ST_RUN: begin
                if (last_lane) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    // Response word is captured once and only changes on the next accept or run completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane  <= '0;
            cc    <= '0;
            rsp_q <= '0;
        end else begin
            if (state == ST_RUN) begin
                cc   <= cc + 32'd1;
                lane <= last_lane ? '0 : lane + LW'(1);
                if (last_lane) begin
                    rsp_q <= 32'(LANES);
                end
            end
            if (accept) begin
                lane <= '0;
                case (op)
                    OP_PING:  rsp_q <= PING_WORD;
                    OP_WRITE: begin
                        rsp_q <= '0;
                        if (id == ID_CC) begin
                            cc <= cmd_data;
                        end
                    end
                    OP_READ:  rsp_q <= (id == ID_CC) ? cc : bank_rd;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_add_cmd.sv
// tb/tb_add_cmd.sv - directed self-checking bench for add_cmd with LANES = 4
module tb_add_cmd;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [1:0]  cmd_id = 2'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    add_cmd #(.LANES(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_id   (cmd_id),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Issue one command, wait for its response and complete the handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] id, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rsp, output int lat);
        int t;
        t = 0;
        cmd_op = op; cmd_id = id; cmd_addr = addr; cmd_data = data;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        while (!cmd_ready && t < 50) begin
            @(posedge clock); #1; t++;
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(posedge clock); #1; t++;
        end
        lat = t + 1;
        rsp = rsp_data;
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL cmd_timeout: rsp_valid=%0b required 1", rsp_valid);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        #1;
        checks += 4;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_ping();
        logic [31:0] r; int lat;
        do_cmd(2'd0, 2'd0, 32'd0, 32'd0, r, lat);
        checks += 3;
        if (r !== 32'hdeadbeef) begin errors++; $display("FAIL ping_data: got %h want deadbeef", r); end
        if (lat != 1) begin errors++; $display("FAIL ping_latency: got %0d want 1", lat); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ping_ready_back: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_run();
        logic [31:0] r; int lat;
        logic [31:0] ra_v [4];
        logic [31:0] rb_v [4];
        logic [31:0] ry_v [4];
        ra_v = '{32'd1, 32'd2, 32'hffffffff, 32'd7};
        rb_v = '{32'd10, 32'd20, 32'd1, 32'd0};
        ry_v = '{32'd11, 32'd22, 32'd0, 32'd7};
        for (int i = 0; i < 4; i++) begin
            do_cmd(2'd1, 2'd1, 32'(i), ra_v[i], r, lat);
            do_cmd(2'd1, 2'd2, 32'(i), rb_v[i], r, lat);
        end
        checks += 2;
        if (r !== 32'h0) begin errors++; $display("FAIL write_rsp: got %h want 0", r); end
        if (lat != 1) begin errors++; $display("FAIL write_latency: got %0d want 1", lat); end
        do_cmd(2'd3, 2'd0, 32'd0, 32'd0, r, lat);
        checks += 2;
        if (r !== 32'd4) begin errors++; $display("FAIL run_rsp: got %0d want 4", r); end
        if (lat != 5) begin errors++; $display("FAIL run_latency: got %0d want 5", lat); end
        for (int i = 0; i < 4; i++) begin
            do_cmd(2'd2, 2'd3, 32'(i), 32'd0, r, lat);
            checks++;
            if (r !== ry_v[i]) begin errors++; $display("FAIL ry_lane%0d: got %h want %h", i, r, ry_v[i]); end
        end
        do_cmd(2'd2, 2'd0, 32'd0, 32'd0, r, lat);
        checks++;
        if (r !== 32'd4) begin errors++; $display("FAIL cc_after_run: got %0d want 4", r); end
    endtask

    task automatic test_cc_wrap();
        logic [31:0] r; int lat;
        do_cmd(2'd1, 2'd0, 32'd7, 32'hfffffffe, r, lat);
        do_cmd(2'd3, 2'd0, 32'd0, 32'd0, r, lat);
        do_cmd(2'd2, 2'd0, 32'd0, 32'd0, r, lat);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL cc_wrap: got %h want 2", r); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] r; int lat;
        logic [31:0] ra_v [4];
        ra_v = '{32'd1, 32'd2, 32'hffffffff, 32'd7};
        do_cmd(2'd1, 2'd1, 32'd9, 32'h12345678, r, lat);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL oob_write_rsp: got %h want 0", r); end
        for (int i = 0; i < 4; i++) begin
            do_cmd(2'd2, 2'd1, 32'(i), 32'd0, r, lat);
            checks++;
            if (r !== ra_v[i]) begin errors++; $display("FAIL oob_ra_lane%0d: got %h want %h", i, r, ra_v[i]); end
        end
        do_cmd(2'd2, 2'd2, 32'd9, 32'd0, r, lat);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL oob_read: got %h want 0", r); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; int lat; int bad;
        bad = 0;
        do_cmd(2'd1, 2'd1, 32'd1, 32'd5, r, lat);
        cmd_op = 2'd2; cmd_id = 2'd1; cmd_addr = 32'd1;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        cmd_op = 2'd0; cmd_id = 2'd0; cmd_addr = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd5 || cmd_ready !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        checks += 2;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %0b want 0", rsp_valid); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %0b want 1", cmd_ready); end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        checks += 2;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pending_accept: got %0b want 1", rsp_valid); end
        if (rsp_data !== 32'hdeadbeef) begin errors++; $display("FAIL pending_data: got %h want deadbeef", rsp_data); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r; int lat; int seen;
        seen = 0;
        cmd_op = 2'd3; cmd_id = 2'd0; cmd_addr = 32'd0;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks += 4;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_cmd_ready: got %0b want 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %0b want 0", rsp_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
        if (rsp_data !== 32'h0) begin errors++; $display("FAIL abort_rsp_data: got %h want 0", rsp_data); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d cycles want 0", seen); end
        for (int i = 0; i < 2; i++) begin
            do_cmd(2'd2, 2'd3, 32'(i), 32'd0, r, lat);
            checks++;
            if (r !== 32'h0) begin errors++; $display("FAIL abort_ry_lane%0d: got %h want 0", i, r); end
        end
        do_cmd(2'd2, 2'd0, 32'd0, 32'd0, r, lat);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL abort_cc: got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_ping();
        test_run();
        test_cc_wrap();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
